// File: rtl/digest_display.sv
// Shows a latched 160-bit SHA-1 digest one 32-bit word at a time on an 8-digit
// active-low seven-segment display; a rising edge on push steps the page h0..h4.
module digest_display #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [159:0] digest,
   input  logic         digest_valid,
   input  logic         push,
   output logic [2:0]   page,
   output logic [7:0]   AN,
   output logic [6:0]   SEG,
   output logic         DP
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

   logic [159:0]     digest_q, digest_d;
   logic             loaded_q, loaded_d;
   logic [2:0]       page_q, page_d;
   logic [2:0]       digit_q, digit_d;
   logic [CNT_W-1:0] refresh_cnt_q, refresh_cnt_d;
   logic             push_d_q, push_d_d;
   logic [7:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;

   logic [31:0]      word;
   logic [3:0]       nibble;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   always_comb begin
      case (page_q)
         3'd0:    word = digest_q[159:128];
         3'd1:    word = digest_q[127:96];
         3'd2:    word = digest_q[95:64];
         3'd3:    word = digest_q[63:32];
         default: word = digest_q[31:0];
      endcase
      nibble = word[{digit_q, 2'b00} +: 4];
   end

   always_comb begin
      digest_d      = digest_q;
      loaded_d      = loaded_q;
      page_d        = page_q;
      push_d_d      = push;
      refresh_cnt_d = refresh_cnt_q + 1'b1;
      digit_d       = digit_q;

      // Capture takes priority over a coincident push edge.
      if (digest_valid) begin
         digest_d = digest;
         loaded_d = 1'b1;
         page_d   = 3'd0;
      end else if (loaded_q && push && !push_d_q) begin
         page_d = (page_q == 3'd4) ? 3'd0 : page_q + 3'd1;
      end

      if (refresh_cnt_q == CNT_MAX) begin
         refresh_cnt_d = '0;
         digit_d       = digit_q + 3'd1;
      end

      an_d  = ~(8'b1 << digit_q);
      seg_d = loaded_q ? hex7(nibble) : 7'b0111111;
      dp_d  = !(loaded_q && (digit_q == page_q));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digest_q      <= '0;
         loaded_q      <= 1'b0;
         page_q        <= 3'd0;
         digit_q       <= 3'd0;
         refresh_cnt_q <= '0;
         push_d_q      <= 1'b0;
         an_q          <= 8'hFF;
         seg_q         <= 7'h7F;
         dp_q          <= 1'b1;
      end else begin
         digest_q      <= digest_d;
         loaded_q      <= loaded_d;
         page_q        <= page_d;
         digit_q       <= digit_d;
         refresh_cnt_q <= refresh_cnt_d;
         push_d_q      <= push_d_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
      end
   end

   assign page = page_q;
   assign AN   = an_q;
   assign SEG  = seg_q;
   assign DP   = dp_q;

endmodule

// File: tb/tb_digest_display.sv
// Bench for digest_display: directed scenarios plus random traffic, checked
// every cycle against a tick/page-count model of the display.
module tb_digest_display;

   localparam int DIV = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [159:0] digest = '0;
   logic         digest_valid = 1'b0;
   logic         push = 1'b0;
   logic [2:0]   page;
   logic [7:0]   AN;
   logic [6:0]   SEG;
   logic         DP;

   int checks = 0;
   int errors = 0;

   digest_display #(.REFRESH_DIV(DIV)) dut (
      .clk(clk), .rst(rst), .digest(digest), .digest_valid(digest_valid),
      .push(push), .page(page), .AN(AN), .SEG(SEG), .DP(DP)
   );

   always #1 clk = ~clk;

   logic [6:0] hex_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: digit follows elapsed ticks since reset, page counts accepted push edges.
   logic [159:0] m_digest;
   logic         m_loaded, m_pushd, m_ok = 1'b0;
   int           m_page, ticks;
   logic [7:0]   e_an;
   logic [6:0]   e_seg;
   logic         e_dp;

   always @(posedge clk) begin
      if (rst) begin
         m_digest = '0; m_loaded = 1'b0; m_pushd = 1'b0; m_page = 0; ticks = 0;
         e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; m_ok = 1'b1;
      end else if (m_ok) begin
         int digit;
         logic [31:0] w;
         logic [3:0]  nib;
         digit = (ticks / DIV) % 8;
         w     = 32'(m_digest >> (32 * (4 - m_page)));
         nib   = 4'(w >> (4 * digit));
         e_an  = ~(8'b1 << digit);
         e_seg = m_loaded ? hex_tab[nib] : 7'b0111111;
         e_dp  = !(m_loaded && digit == m_page);
         ticks++;
         if (digest_valid) begin
            m_digest = digest; m_loaded = 1'b1; m_page = 0;
         end else if (push && !m_pushd && m_loaded) begin
            m_page = (m_page + 1) % 5;
         end
         m_pushd = push;
      end
      #1;
      if (m_ok) begin
         chk("model_AN", 32'(AN), 32'(e_an));
         chk("model_SEG", 32'(SEG), 32'(e_seg));
         chk("model_DP", 32'(DP), 32'(e_dp));
         chk("model_page", 32'(page), 32'(m_page));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse();
      push = 1'b1; step(3);
      push = 1'b0; step(3);
   endtask

   task automatic wait_an(input logic [7:0] v, input string nm);
      int n = 0;
      while (AN !== v && n < 100) begin
         step(1);
         n++;
      end
      chk(nm, 32'(n < 100), 32'd1);
   endtask

   initial begin
      logic [159:0] d0;
      d0 = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0};

      // Reset held for three edges.
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("rst_AN", 32'(AN), 32'hFF);
         chk("rst_SEG", 32'(SEG), 32'h7F);
         chk("rst_DP", 32'(DP), 32'd1);
         chk("rst_page", 32'(page), 32'd0);
      end

      // Idle scan: one anode low, stepping every DIV clocks, dashes.
      rst = 1'b0;
      step(1);
      for (int k = 0; k < 9; k++) begin
         logic [7:0] exp_an;
         exp_an = ~(8'b1 << (k % 8));
         chk("scan_AN", 32'(AN), 32'(exp_an));
         chk("idle_SEG", 32'(SEG), 32'b0111111);
         chk("idle_DP", 32'(DP), 32'd1);
         step(DIV);
      end

      // Load the reference digest.
      digest = d0; digest_valid = 1'b1; step(1);
      digest_valid = 1'b0; digest = '0; step(1);
      chk("load_page", 32'(page), 32'd0);
      wait_an(8'hFE, "wait_d0");
      chk("p0_d0_SEG", 32'(SEG), 32'b1111001);
      chk("p0_d0_DP", 32'(DP), 32'd0);
      wait_an(8'h7F, "wait_d7");
      chk("p0_d7_SEG", 32'(SEG), 32'b0000010);
      chk("p0_d7_DP", 32'(DP), 32'd1);

      // Five pulses walk the pages and wrap.
      for (int i = 1; i <= 5; i++) begin
         pulse();
         chk("push_page", 32'(page), 32'(i % 5));
         if (i == 3) begin
            wait_an(8'hFE, "wait_p3");
            chk("p3_d0_SEG", 32'(SEG), 32'b0000010);
         end
         if (i == 4) begin
            wait_an(8'hFE, "wait_p4");
            chk("p4_d0_SEG", 32'(SEG), 32'b1000000);
            chk("p4_d0_DP", 32'(DP), 32'd1);
         end
      end

      // Capture and push edge together: capture wins.
      pulse(); pulse(); pulse();
      chk("pre_tie_page", 32'(page), 32'd3);
      digest = {$urandom, $urandom, $urandom, $urandom, $urandom};
      digest_valid = 1'b1; push = 1'b1; step(1);
      digest_valid = 1'b0; step(2);
      push = 1'b0; step(3);
      chk("tie_page", 32'(page), 32'd0);
      step(20);

      // Reset mid-scan while loaded.
      wait_an(8'hDF, "wait_d5");
      rst = 1'b1; step(1);
      chk("midrst_AN", 32'(AN), 32'hFF);
      chk("midrst_SEG", 32'(SEG), 32'h7F);
      rst = 1'b0; step(2);
      pulse(); pulse();
      chk("unloaded_page", 32'(page), 32'd0);
      chk("unloaded_SEG", 32'(SEG), 32'b0111111);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 399) == 0);
         digest_valid = ($urandom_range(0, 59) == 0);
         digest = {$urandom, $urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 3) == 0) push = ~push;
         step(1);
      end
      rst = 1'b0; digest_valid = 1'b0; push = 1'b0;
      step(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
